// File: rtl/delay_line_pkg.sv
// Shared helpers for the delay_line block: tap-width sizing and tap clamping.
package delay_line_pkg;

    // Width of a tap/count field able to hold 0..depth.
    function automatic int tap_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

    // Effective tap: out-of-range selections (0 or above depth) fall back to the full depth.
    function automatic int tap_clamp(input int tap, input int depth);
        return (tap >= 1 && tap <= depth) ? tap : depth;
    endfunction

endpackage

// File: rtl/delay_line_if.sv
// Data/control bundle for delay_line. The master side drives the stream and tap;
// the slave side (the delay line itself) returns the delayed data and occupancy.
interface delay_line_if
    import delay_line_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int TAPW = tap_width(DEPTH);

    logic             en;
    logic             clr;
    logic [WIDTH-1:0] D;
    logic             d_valid;
    logic [TAPW-1:0]  tap;
    logic [WIDTH-1:0] Q;
    logic             q_valid;
    logic [TAPW-1:0]  count;
    logic             full;

    modport master (
        output en, clr, D, d_valid, tap,
        input  Q, q_valid, count, full
    );

    modport slave (
        input  en, clr, D, d_valid, tap,
        output Q, q_valid, count, full
    );
endinterface

// File: rtl/delay_line_d_reg.sv
// One delay stage: enable-gated register with synchronous clear and async active-low reset.
module d_reg #(
    parameter int WIDTH = 9
) (
    input  logic             CLK,
    input  logic             n_res,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    // Clear beats enable; otherwise capture on enable, else hold.
    always_ff @(posedge CLK or negedge n_res) begin
        if (!n_res) begin
            Q <= '0;
        end else if (clr) begin
            Q <= '0;
        end else if (en) begin
            Q <= D;
        end
    end

endmodule

// File: rtl/delay_line.sv
// Programmable delay line: DEPTH chained stages carrying data plus a valid bit,
// with a live-selectable output tap, occupancy count and full flag.
module delay_line
    import delay_line_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic         CLK,
    input  logic         n_res,
    delay_line_if.slave  bus
);

    localparam int TAPW = tap_width(DEPTH);

    // Each stage holds {valid, data}; valid sits in the top bit.
    logic [WIDTH:0]   st [DEPTH];
    logic [TAPW-1:0]  cnt;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH:0] din;

        if (i == 0) begin : g_head
            assign din = {bus.d_valid, bus.D};
        end else begin : g_tail
            assign din = st[i-1];
        end

        d_reg #(.WIDTH(WIDTH + 1)) u_reg (
            .CLK   (CLK),
            .n_res (n_res),
            .en    (bus.en),
            .clr   (bus.clr),
            .D     (din),
            .Q     (st[i])
        );
    end

    // Output tap select; data is masked to zero whenever the selected stage is a bubble.
    always_comb begin
        int sel;
        bus.Q       = '0;
        bus.q_valid = 1'b0;
        sel         = tap_clamp(int'(bus.tap), DEPTH) - 1;
        for (int i = 0; i < DEPTH; i++) begin
            if (i == sel) begin
                bus.q_valid = st[i][WIDTH];
                bus.Q       = st[i][WIDTH] ? st[i][WIDTH-1:0] : '0;
            end
        end
    end

    // Occupancy: number of stages currently holding a valid sample.
    always_comb begin
        cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt = cnt + TAPW'(st[i][WIDTH]);
        end
    end

    assign bus.count = cnt;
    assign bus.full  = (cnt == TAPW'(DEPTH));

endmodule

// File: tb/tb_delay_line.sv
`timescale 1ns/1ps
// Directed bench for delay_line (WIDTH=8, DEPTH=4): reset, latency, stall,
// clear priority, tap clamping and bubble propagation.
module tb_delay_line;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic CLK = 1'b0;
    logic n_res = 1'b0;
    int   total = 0;
    int   bad   = 0;

    delay_line_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK   (CLK),
        .n_res (n_res),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs on the negedge, then sample #1 after the next posedge.
    task automatic cyc(input logic e, input logic c, input logic [7:0] d, input logic dv);
        @(negedge CLK);
        bus.en      = e;
        bus.clr     = c;
        bus.D       = d;
        bus.d_valid = dv;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] q, input logic qv,
                           input logic [2:0] cnt, input logic fl);
        chk({tag, ".Q"},       32'(bus.Q),       32'(q));
        chk({tag, ".q_valid"}, 32'(bus.q_valid), 32'(qv));
        chk({tag, ".count"},   32'(bus.count),   32'(cnt));
        chk({tag, ".full"},    32'(bus.full),    32'(fl));
    endtask

    initial begin
        bus.en = 1'b0; bus.clr = 1'b0; bus.D = '0; bus.d_valid = 1'b0; bus.tap = 3'd4;
        #12;
        chk_out("reset", 8'h00, 1'b0, 3'd0, 1'b0);
        @(negedge CLK);
        n_res = 1'b1;

        // Fill with A5, then pulse reset between edges.
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 8'hA5, 1'b1);
        chk_out("filled", 8'hA5, 1'b1, 3'd4, 1'b1);
        #1;
        n_res = 1'b0;
        #0.005;
        chk_out("rst_mid", 8'h00, 1'b0, 3'd0, 1'b0);
        #0.010;
        n_res = 1'b1;
        #0.005;
        chk_out("rst_rel", 8'h00, 1'b0, 3'd0, 1'b0);

        // Latency with tap=3.
        bus.tap = 3'd3;
        cyc(1'b1, 1'b0, 8'h11, 1'b1);
        chk("dly1.q_valid", 32'(bus.q_valid), 32'd0);
        cyc(1'b1, 1'b0, 8'h22, 1'b1);
        chk("dly2.q_valid", 32'(bus.q_valid), 32'd0);
        cyc(1'b1, 1'b0, 8'h33, 1'b1);
        chk_out("dly3", 8'h11, 1'b1, 3'd3, 1'b0);
        cyc(1'b1, 1'b0, 8'h44, 1'b1);
        chk("dly4.Q", 32'(bus.Q), 32'h22);
        cyc(1'b1, 1'b0, 8'h55, 1'b1);
        chk("dly5.Q", 32'(bus.Q), 32'h33);

        // Stall with tap=2.
        cyc(1'b0, 1'b1, 8'h00, 1'b0);
        chk_out("clr0", 8'h00, 1'b0, 3'd0, 1'b0);
        bus.tap = 3'd2;
        cyc(1'b1, 1'b0, 8'h5A, 1'b1);
        chk_out("stall_cap", 8'h00, 1'b0, 3'd1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 8'h77, 1'b1);
            chk_out("stall_hold", 8'h00, 1'b0, 3'd1, 1'b0);
        end
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        chk_out("stall_go", 8'h5A, 1'b1, 3'd1, 1'b0);

        // Clear beats enable.
        bus.tap = 3'd4;
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 8'(i + 8'h10), 1'b1);
        chk_out("full", 8'h10, 1'b1, 3'd4, 1'b1);
        cyc(1'b1, 1'b1, 8'hFF, 1'b1);
        chk_out("clr_pri", 8'h00, 1'b0, 3'd0, 1'b0);

        // Tap clamp and live change: stages s0..s3 = 4,3,2,1.
        for (int i = 1; i <= 4; i++) cyc(1'b1, 1'b0, 8'(i), 1'b1);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        bus.tap = 3'd0; #1;
        chk("tap0.Q", 32'(bus.Q), 32'h1);
        bus.tap = 3'd7; #1;
        chk("tap7.Q", 32'(bus.Q), 32'h1);
        bus.tap = 3'd2; #1;
        chk("tap2.Q", 32'(bus.Q), 32'h3);
        bus.tap = 3'd1; #1;
        chk("tap1.Q", 32'(bus.Q), 32'h4);

        // Bubbles with tap=1.
        cyc(1'b0, 1'b1, 8'h00, 1'b0);
        cyc(1'b1, 1'b0, 8'h01, 1'b1);
        chk("bub1.Q", 32'(bus.Q), 32'h01);
        chk("bub1.q_valid", 32'(bus.q_valid), 32'd1);
        cyc(1'b1, 1'b0, 8'hEE, 1'b0);
        chk("bub2.Q", 32'(bus.Q), 32'h00);
        chk("bub2.q_valid", 32'(bus.q_valid), 32'd0);
        cyc(1'b1, 1'b0, 8'h03, 1'b1);
        chk("bub3.Q", 32'(bus.Q), 32'h03);
        chk("bub3.q_valid", 32'(bus.q_valid), 32'd1);
        chk("bub3.count", 32'(bus.count), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
